// File: rtl/seq_bit_packer.sv
// seq_bit_packer
//
// Takes the 1-bit serial stream of sync_seq_machine, hunts for a
// programmable sync pattern and then packs the following bits MSB-first
// into WIDTH-bit words. FRAME_WORDS words are delivered per frame over a
// valid/ready handshake. After the frame the block drops lock and hunts
// for the next sync pattern.
//
// Parameters:
//   WIDTH        data word width (>= 2)
//   SYNC_LEN     sync pattern length in bits (1..16)
//   SYNC         sync pattern, last-received bit in the LSB
//   FRAME_WORDS  words collected after each sync match (>= 1)
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high; clears all state
//   bit_in       serial data input
//   bit_en       bit_in is consumed only when this is high
//   word_out     packed word, first-received bit in the MSB
//   word_valid   word_out holds an unconsumed word
//   word_ready   downstream accepts; transfer on word_valid & word_ready
//   locked       high while collecting frame data
//   overflow     sticky; a completed word was dropped
//   word_parity  (only with SEQ_BIT_PACKER_PARITY_EN) XOR of word_out
//
// Optional feature macro: SEQ_BIT_PACKER_PARITY_EN adds word_parity.

module seq_bit_packer #(
  parameter int                  WIDTH       = 8,
  parameter int                  SYNC_LEN    = 4,
  parameter logic [SYNC_LEN-1:0] SYNC        = 4'b1101,
  parameter int                  FRAME_WORDS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             locked,
  output logic             overflow
`ifdef SEQ_BIT_PACKER_PARITY_EN
  ,
  output logic             word_parity
`endif
);

  localparam int BIT_W  = $clog2(WIDTH);
  localparam int SEEN_W = $clog2(SYNC_LEN + 1);
  localparam int WORD_W = $clog2(FRAME_WORDS + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [SEEN_W-1:0] SEEN_MAX  = SEEN_W'(SYNC_LEN);
  localparam logic [SEEN_W-1:0] SEEN_ARM  = SEEN_W'(SYNC_LEN - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FRAME_WORDS - 1);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t              state, state_n;
  logic [SYNC_LEN-1:0] sync_sr, sync_n;
  logic [SEEN_W-1:0]   seen, seen_n;
  logic [BIT_W-1:0]    bit_cnt, bit_n;
  logic [WORD_W-1:0]   word_cnt, wcnt_n;
  logic [WIDTH-1:0]    shift_sr, shift_n;
  logic [WIDTH-1:0]    word_n;
  logic                valid_n;
  logic                ovf_n;

  logic [SYNC_LEN-1:0] sync_shift;
  logic [WIDTH-1:0]    word_shift;
  logic                hunt_match;
  logic                xfer;
  logic                out_free;

`ifdef SEQ_BIT_PACKER_PARITY_EN
  logic                par_n;
`endif

  // Shifted views of both registers including the bit presented this
  // cycle. The match uses the shifted value so the final sync bit counts
  // in the same cycle it arrives. Requiring SYNC_LEN-1 earlier bits keeps
  // leftover register contents from ever matching.
  assign sync_shift = (sync_sr << 1) | SYNC_LEN'(bit_in);
  assign word_shift = (shift_sr << 1) | WIDTH'(bit_in);
  assign hunt_match = (sync_shift == SYNC) && (seen >= SEEN_ARM);
  assign xfer       = word_valid & word_ready;
  assign out_free   = !word_valid || word_ready;
  assign locked     = (state == COLLECT);

  // Next-state logic. The handshake completes regardless of bit_en; a
  // word completing in a transfer cycle reloads the output register so
  // back-to-back words never bubble. A word that cannot be loaded is
  // dropped, but it still counts toward the end of the frame.
  always_comb begin
    state_n = state;
    sync_n  = sync_sr;
    seen_n  = seen;
    bit_n   = bit_cnt;
    wcnt_n  = word_cnt;
    shift_n = shift_sr;
    word_n  = word_out;
    valid_n = word_valid;
    ovf_n   = overflow;
`ifdef SEQ_BIT_PACKER_PARITY_EN
    par_n   = word_parity;
`endif

    if (xfer) begin
      valid_n = 1'b0;
    end

    case (state)
      HUNT: begin
        if (bit_en) begin
          sync_n = sync_shift;
          seen_n = (seen == SEEN_MAX) ? seen : seen + SEEN_W'(1);
          if (hunt_match) begin
            state_n = COLLECT;
            bit_n   = '0;
            wcnt_n  = '0;
          end
        end
      end
      COLLECT: begin
        if (bit_en) begin
          shift_n = word_shift;
          if (bit_cnt == BIT_LAST) begin
            bit_n = '0;
            if (word_cnt == WORD_LAST) begin
              state_n = HUNT;
              seen_n  = '0;
              wcnt_n  = '0;
            end else begin
              wcnt_n = word_cnt + WORD_W'(1);
            end
            if (out_free) begin
              word_n  = word_shift;
              valid_n = 1'b1;
`ifdef SEQ_BIT_PACKER_PARITY_EN
              par_n   = ^word_shift;
`endif
            end else begin
              ovf_n = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_n = HUNT;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      sync_sr    <= '0;
      seen       <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      shift_sr   <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
`ifdef SEQ_BIT_PACKER_PARITY_EN
      word_parity <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sync_sr    <= sync_n;
      seen       <= seen_n;
      bit_cnt    <= bit_n;
      word_cnt   <= wcnt_n;
      shift_sr   <= shift_n;
      word_out   <= word_n;
      word_valid <= valid_n;
      overflow   <= ovf_n;
`ifdef SEQ_BIT_PACKER_PARITY_EN
      word_parity <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_seq_bit_packer.sv
// Testbench for seq_bit_packer (WIDTH=8, SYNC_LEN=4, SYNC=4'b1101,
// FRAME_WORDS=2). Directed scenarios followed by randomized traffic
// checked against a bit-stream level reference model.

module tb_seq_bit_packer;

  localparam int W        = 8;
  localparam int SL       = 4;
  localparam int SYNC_VAL = 13;
  localparam int FW       = 2;

  logic         clk;
  logic         reset;
  logic         bit_in;
  logic         bit_en;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready;
  logic         locked;
  logic         overflow;
`ifdef SEQ_BIT_PACKER_PARITY_EN
  logic         word_parity;
`endif

  int vectors;
  int miscompares;

  // Reference model state: bits seen since hunting began, the value of
  // the last SL bits, the running data value, and the output slot.
  int m_seen, m_last, m_data, m_nbits, m_nwords, m_word;
  bit m_locked, m_valid, m_ovf;
`ifdef SEQ_BIT_PACKER_PARITY_EN
  bit m_par;
`endif

  seq_bit_packer #(
    .WIDTH(W), .SYNC_LEN(SL), .SYNC(4'b1101), .FRAME_WORDS(FW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bit_in(bit_in),
    .bit_en(bit_en),
    .word_out(word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .locked(locked),
    .overflow(overflow)
`ifdef SEQ_BIT_PACKER_PARITY_EN
    ,
    .word_parity(word_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update(input logic r, input logic e, input logic b, input logic w);
    bit xfer;
    bit done;
    if (r) begin
      m_seen = 0; m_last = 0; m_data = 0; m_nbits = 0; m_nwords = 0;
      m_word = 0; m_locked = 0; m_valid = 0; m_ovf = 0;
`ifdef SEQ_BIT_PACKER_PARITY_EN
      m_par = 0;
`endif
      return;
    end
    xfer = m_valid && w;
    done = 0;
    if (e) begin
      if (!m_locked) begin
        m_seen++;
        m_last = (m_last * 2 + int'(b)) % (1 << SL);
        if (m_seen >= SL && m_last == SYNC_VAL) begin
          m_locked = 1; m_nbits = 0; m_nwords = 0;
        end
      end else begin
        m_data = (m_data * 2 + int'(b)) % (1 << W);
        m_nbits++;
        if (m_nbits == W) begin
          done = 1; m_nbits = 0; m_nwords++;
          if (m_nwords == FW) begin
            m_locked = 0; m_seen = 0;
          end
        end
      end
    end
    if (done && (!m_valid || xfer)) begin
      m_word = m_data; m_valid = 1;
`ifdef SEQ_BIT_PACKER_PARITY_EN
      m_par = ($countones(m_data) % 2) == 1;
`endif
    end else begin
      if (xfer) m_valid = 0;
      if (done) m_ovf = 1;
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // leave time 1 unit past the edge for sampling.
  task automatic step(input logic r, input logic e, input logic b, input logic w);
    reset = r; bit_en = e; bit_in = b; word_ready = w;
    @(posedge clk);
    model_update(r, e, b, w);
    #1;
  endtask

  task automatic send_sync(input logic w);
    step(0, 1, 1, w); step(0, 1, 1, w); step(0, 1, 0, w); step(0, 1, 1, w);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic w);
    for (int i = 7; i >= 0; i--) step(0, 1, v[i], w);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, logic'(i % 2), 1);
      vectors++;
      if (word_out !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_word_out: got %h expected 00", word_out); end
      vectors++;
      if (word_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", word_valid); end
      vectors++;
      if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
      vectors++;
      if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    end
  endtask

  task automatic test_basic_word;
    logic [7:0] data;
    int pulses;
    data = 8'hA5;
    pulses = 0;
    step(1, 0, 0, 1);
    step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 0, 1);
    vectors++;
    if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_early_lock: got %b expected 0", locked); end
    step(0, 1, 1, 1);
    vectors++;
    if (locked !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_lock: got %b expected 1", locked); end
    for (int i = 7; i >= 0; i--) begin
      step(0, 1, data[i], 1);
      if (word_valid === 1'b1) pulses++;
    end
    vectors++;
    if (word_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_valid: got %b expected 1", word_valid); end
    vectors++;
    if (word_out !== 8'hA5) begin miscompares++; $display("[TB] FAIL basic_word: got %h expected a5", word_out); end
    step(0, 0, 0, 1);
    if (word_valid === 1'b1) pulses++;
    vectors++;
    if (pulses != 1) begin miscompares++; $display("[TB] FAIL basic_pulse_count: got %0d expected 1", pulses); end
  endtask

  task automatic test_stretched;
    logic [11:0] stream;
    int pulses;
    stream = 12'b1101_10100101;
    pulses = 0;
    step(1, 0, 0, 1);
    for (int i = 11; i >= 0; i--) begin
      step(0, 1, stream[i], 1);
      if (word_valid === 1'b1) pulses++;
      if (i == 8) begin
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("[TB] FAIL stretch_lock: got %b expected 1", locked); end
      end
      if (i == 0) begin
        vectors++;
        if (word_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stretch_valid: got %b expected 1", word_valid); end
        vectors++;
        if (word_out !== 8'hA5) begin miscompares++; $display("[TB] FAIL stretch_word: got %h expected a5", word_out); end
      end
      step(0, 0, ~stream[i], 1);
      if (word_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("[TB] FAIL stretch_pulse_count: got %0d expected 1", pulses); end
  endtask

  task automatic test_overflow;
    step(1, 0, 0, 0);
    send_sync(0);
    send_byte(8'h3C, 0);
    send_byte(8'hFF, 0);
    vectors++;
    if (word_out !== 8'h3C) begin miscompares++; $display("[TB] FAIL ovf_hold_word: got %h expected 3c", word_out); end
    vectors++;
    if (word_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_valid: got %b expected 1", word_valid); end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    vectors++;
    if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_unlock: got %b expected 0", locked); end
    step(0, 0, 0, 1);
    vectors++;
    if (word_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_transfer: got %b expected 0", word_valid); end
    step(0, 0, 0, 1);
    vectors++;
    if (word_valid !== 1'b0 || overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_after: got valid=%b ovf=%b expected valid=0 ovf=1", word_valid, overflow);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] nosync;
    nosync = 8'b1001_0010;
    step(1, 0, 0, 1);
    send_sync(1);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1);
    step(1, 0, 0, 1);
    vectors++;
    if (locked !== 1'b0 || word_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: got locked=%b valid=%b expected 0 0", locked, word_valid);
    end
    for (int i = 7; i >= 0; i--) begin
      step(0, 1, nosync[i], 1);
      vectors++;
      if (word_valid !== 1'b0 || locked !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL midreset_nosync: got locked=%b valid=%b expected 0 0", locked, word_valid);
      end
    end
  endtask

`ifdef SEQ_BIT_PACKER_PARITY_EN
  task automatic test_parity;
    step(1, 0, 0, 1);
    send_sync(1);
    send_byte(8'h07, 1);
    vectors++;
    if (word_out !== 8'h07 || word_parity !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL parity_07: got word=%h par=%b expected 07 1", word_out, word_parity);
    end
    send_byte(8'h03, 1);
    vectors++;
    if (word_out !== 8'h03 || word_parity !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL parity_03: got word=%h par=%b expected 03 0", word_out, word_parity);
    end
  endtask
`endif

  task automatic test_random;
    int en_pct;
    int rdy_pct;
    for (int ep = 0; ep < 4; ep++) begin
      en_pct  = 50 + ep * 15;
      rdy_pct = 100 - ep * 20;
      step(1, 0, 0, 0);
      for (int c = 0; c < 600; c++) begin
        step(0, logic'($urandom_range(99) < en_pct), logic'($urandom_range(1)),
             logic'($urandom_range(99) < rdy_pct));
        vectors++;
        if (word_valid !== logic'(m_valid)) begin miscompares++; $display("[TB] FAIL rand_valid c=%0d: got %b expected %b", c, word_valid, m_valid); end
        vectors++;
        if (locked !== logic'(m_locked)) begin miscompares++; $display("[TB] FAIL rand_locked c=%0d: got %b expected %b", c, locked, m_locked); end
        vectors++;
        if (overflow !== logic'(m_ovf)) begin miscompares++; $display("[TB] FAIL rand_overflow c=%0d: got %b expected %b", c, overflow, m_ovf); end
        vectors++;
        if (word_out !== W'(m_word)) begin miscompares++; $display("[TB] FAIL rand_word c=%0d: got %h expected %h", c, word_out, W'(m_word)); end
`ifdef SEQ_BIT_PACKER_PARITY_EN
        vectors++;
        if (word_parity !== logic'(m_par)) begin miscompares++; $display("[TB] FAIL rand_parity c=%0d: got %b expected %b", c, word_parity, m_par); end
`endif
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; bit_en = 1'b0; bit_in = 1'b0; word_ready = 1'b0;
    test_reset;
    test_basic_word;
    test_stretched;
    test_overflow;
    test_reset_mid;
`ifdef SEQ_BIT_PACKER_PARITY_EN
    test_parity;
`endif
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_bit_packer.md
# seq_bit_packer

Downstream consumer of the `sync_seq_machine` serial output. It hunts the 1-bit stream for a programmable sync pattern, then packs the following bits MSB-first into WIDTH-bit words. Each frame of FRAME_WORDS words is delivered over a valid/ready handshake. After the frame it drops lock and re-hunts. This turns the FSM's bit-level output into word-level data for the checkers and loggers further down the chain.

## Interface
- WIDTH, 8, data word width (≥2)
- SYNC_LEN, 4, sync pattern length in bits (1..16)
- SYNC, 4'b1101, sync pattern; last-received bit is LSB
- FRAME_WORDS, 4, words per frame after each sync match (≥1)

Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; all state cleared on the clk edge where it is sampled high
- bit_in  in  1  serial data; connects to `sync_seq_machine.out`
- bit_en  in  1  qualifier; bit_in is consumed only in cycles where bit_en=1
- word_out  out  WIDTH  packed word, first-received bit in the MSB
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  downstream accepts; a transfer occurs when word_valid & word_ready
- locked  out  1  state is COLLECT
- overflow  out  1  sticky; a completed word was dropped

## Operation
- States: HUNT, COLLECT.
- Reset values: HUNT, word_out=0, word_valid=0, locked=0, overflow=0. Sync shift register, bits-seen counter, bit counter and word counter are all 0.

HUNT:
- Each bit_en cycle, bit_in shifts into the SYNC_LEN-bit sync register at the LSB. A saturating bits-seen counter increments.
- A match is the shifted value (including the current bit) equal to SYNC, with bits-seen ≥ SYNC_LEN counting the current bit. Because of the bits-seen condition, register contents left over from reset never produce a false match.
- On a match: go to COLLECT, clear the bit and word counters, and set locked=1.

COLLECT:
- Each bit_en cycle, bit_in shifts into the word shift register and the bit counter increments.
- On the bit_en cycle with bit counter = WIDTH-1 (the word is complete):
  - The bit counter wraps to 0 and the word counter increments.
  - If the output register is free, or is being transferred this same cycle, load word_out and set word_valid=1.
  - Otherwise drop the new word, keep the old word_out, and set overflow=1.
- When the completed word is number FRAME_WORDS, return to HUNT, clear bits-seen and set locked=0. This happens whether that word was loaded or dropped.

Handshake:
- word_valid stays high until a transfer cycle. It falls after that cycle unless a new word loads in the same cycle.
- word_out is stable while word_valid=1 and no transfer has occurred.
- word_ready is ignored while word_valid=0.

Other rules:
- bit_en=0: no state changes except handshake completion.
- overflow is cleared only by reset.

## Timing
- locked rises on the clk edge that samples the final sync bit; it is visible the following cycle.
- Word latency: word_valid and word_out update on the edge that samples the WIDTH-th data bit (one cycle after that bit is presented).
- Back-to-back: with bit_en=1 continuously and word_ready=1, a new word appears every WIDTH cycles with no bubbles.
- Frame rollover: the first HUNT bit is the bit right after the last data bit. A new sync needs at least SYNC_LEN further bit_en cycles.
- Reset mid-operation: the partial word is discarded and any pending word_valid is cleared. The next frame requires a fresh sync.

## Configuration
- Macro `SEQ_BIT_PACKER_PARITY_EN`.
- Defined: adds output port `word_parity` (out, 1) = XOR of the loaded word. It is registered with word_out, stable under the same rules, and resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
(WIDTH=8, SYNC_LEN=4, SYNC=4'b1101, FRAME_WORDS=2 unless stated)
- Hold reset=1 for 3 clk with bit_in toggling -> word_out=0, word_valid=0, locked=0, overflow=0 throughout.
- bit_en=1, bits 1,1,0,1 then 1,0,1,0,0,1,0,1, word_ready=1 -> locked=1 the cycle after the 4th bit; word_valid=1 for exactly one cycle with word_out=8'hA5.
- Same stream with bit_en=0 on every other cycle -> same word 8'hA5, with the valid pulse at the stretched position.
- Sync, then words 8'h3C and 8'hFF with word_ready=0 -> word_out holds 8'h3C, overflow=1, locked=0 after the 2nd word. Raising word_ready then gives one transfer of 8'h3C.
- Sync, 5 data bits, then reset=1 for 1 cycle -> locked=0 and word_valid=0; the next 8 bits without a sync produce no word.
- With `SEQ_BIT_PACKER_PARITY_EN` defined: sync then 8'h07 -> word_parity=1. A following word 8'h03 -> word_parity=0.
